dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/mips_pkg.sv | 23 ++
 rtl/arb_age_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory path: arbiter states, owner ids and
// the default starvation limit for the debug/loader port.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  localparam int MAX_WAIT_DEFAULT = 4;
  localparam int WAIT_W           = 4;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Starvation counter for the debug port: counts refused cycles, saturates at
// MAX_WAIT and flags saturation so the arbiter can hand the debug port priority.
module arb_age_counter
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] count,
  output logic              sat
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  assign sat = (count == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and the debug/loader port.
// One access per three cycles: latch winner in IDLE, drive memory in ACCESS, ack in RESP.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e          state, state_next;
  owner_e              owner;
  logic                lat_we;
  logic [ADDR_W+1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic                load, grant_dbg;
  logic                age_inc, age_sat;
  logic [WAIT_W-1:0]   age_count;
  logic                in_access, in_resp, misaligned;
  logic [31:0]         resp_data;
  logic                unused_addr_bits;

  // Word addresses wrap modulo the memory size, so upper byte-address bits are dropped.
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2], age_count};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    grant_dbg  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          load       = 1'b1;
          grant_dbg  = dbg_req && (!cpu_req || age_sat);
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWNER_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (load) begin
      owner     <= grant_dbg ? OWNER_DBG : OWNER_CPU;
      lat_we    <= grant_dbg ? dbg_we : cpu_we;
      lat_addr  <= grant_dbg ? dbg_addr[ADDR_W+1:0] : cpu_addr[ADDR_W+1:0];
      lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
    end
  end

  // The debug port only ages while it is neither being granted nor already being served.
  assign age_inc = dbg_req && !grant_dbg && !((state != IDLE) && (owner == OWNER_DBG));

  arb_age_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk  (clk),
    .reset(reset),
    .inc  (age_inc),
    .clr  (grant_dbg),
    .count(age_count),
    .sat  (age_sat)
  );

  assign in_access  = (state == ACCESS);
  assign in_resp    = (state == RESP);
  assign misaligned = is_misaligned(lat_addr[1:0]);

  assign mem_en    = in_access && !misaligned;
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = in_access ? lat_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;

  assign resp_data = (in_resp && !lat_we && !misaligned) ? mem_rdata : '0;
  assign cpu_ack   = in_resp && (owner == OWNER_CPU);
  assign dbg_ack   = in_resp && (owner == OWNER_DBG);
  assign cpu_rdata = cpu_ack ? resp_data : '0;
  assign dbg_rdata = dbg_ack ? resp_data : '0;
  assign err       = in_resp && misaligned;
  assign cpu_stall = cpu_req && !cpu_ack;

endmodule
